// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses the PLL reset, waits for a synchronized lock,
// qualifies it over a stable window and only then releases the downstream reset.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 10000,
    parameter int STABLE_CYCLES  = 256,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fail,
    output logic [7:0] loss_count,
    output logic [2:0] state
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CYC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CW      = $clog2(MAX_CYC + 1);
    localparam int RW      = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {
        S_PLLRST = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retries_q, retries_d, retries_inc;
    logic [7:0]    loss_q, loss_d;
    logic          sync1_q, locked_s;

    assign retries_inc = retries_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        retries_d = retries_q;
        loss_d    = loss_q;
        case (state_q)
            S_PLLRST: begin
                if (cnt_q == CW'(PLL_RST_CYCLES - 1)) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A lock arriving on the timeout cycle wins over the retry.
                if (locked_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
                    retries_d = retries_inc;
                    state_d   = (retries_inc == RW'(MAX_RETRIES)) ? S_FAIL : S_PLLRST;
                end
            end
            S_STABLE: begin
                if (!locked_s) begin
                    state_d = S_WAIT;
                end else if (cnt_q == CW'(STABLE_CYCLES - 1)) begin
                    state_d   = S_RUN;
                    retries_d = '0;
                end
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_d = S_PLLRST;
                    if (loss_q != 8'hFF) loss_d = loss_q + 8'd1;
                end
            end
            S_FAIL: state_d = S_FAIL;
            default: state_d = S_PLLRST;
        endcase

        // Counter only times PLLRST/WAIT/STABLE; it restarts on every transition.
        if (state_d != state_q || state_q == S_RUN || state_q == S_FAIL) cnt_d = '0;
        else cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            locked_s  <= 1'b0;
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            retries_q <= '0;
            loss_q    <= 8'd0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            fail      <= 1'b0;
        end else begin
            sync1_q   <= locked;
            locked_s  <= sync1_q;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retries_q <= retries_d;
            loss_q    <= loss_d;
            // Outputs are decoded from the next state so they line up with state_q.
            pll_rst   <= (state_d == S_PLLRST) || (state_d == S_FAIL);
            sys_rst   <= (state_d != S_RUN);
            ready     <= (state_d == S_RUN);
            fail      <= (state_d == S_FAIL);
        end
    end

    assign loss_count = loss_q;
    assign state      = state_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: per-cycle expected traces of state, resets,
// ready, fail and loss_count are queued from the scenario timing and compared.
module tb_pll_lock_supervisor;

    logic        refclk = 1'b0;
    logic        rst    = 1'b1;
    logic        locked = 1'b0;
    logic        pll_rst, sys_rst, ready, fail;
    logic [7:0]  loss_count;
    logic [2:0]  state;

    logic [14:0] exp_q[$];
    logic [14:0] obs, exp_v;
    int          n_checks = 0;
    int          n_fail   = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .pll_rst   (pll_rst),
        .sys_rst   (sys_rst),
        .ready     (ready),
        .fail      (fail),
        .loss_count(loss_count),
        .state     (state)
    );

    always #5 refclk = ~refclk;

    task automatic tick();
        @(posedge refclk);
        #1;
    endtask

    // Output pattern each state must show: {loss, state, pll_rst, sys_rst, ready, fail}.
    function automatic logic [14:0] exp_word(input int st, input int loss);
        logic [7:0] l8;
        logic [2:0] s3;
        l8 = loss[7:0];
        s3 = st[2:0];
        return {l8, s3, (st == 0 || st == 4), (st != 3), (st == 3), (st == 4)};
    endfunction

    task automatic push_seg(input int st, input int n, input int loss);
        for (int k = 0; k < n; k++) exp_q.push_back(exp_word(st, loss));
    endtask

    task automatic test_reset();
        rst    = 1'b1;
        locked = 1'($urandom_range(0, 1));
        exp_q.push_back(exp_word(0, 0));
        tick();
        obs   = {loss_count, state, pll_rst, sys_rst, ready, fail};
        exp_v = exp_q.pop_front();
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", obs, exp_v);
        end
    endtask

    task automatic test_lock_up();
        int n;
        push_seg(0, 4, 0); push_seg(1, 1, 0); push_seg(2, 8, 0); push_seg(3, 5, 0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            rst    = (i == 0);
            locked = 1'b1;
            tick();
            obs   = {loss_count, state, pll_rst, sys_rst, ready, fail};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lock_up cycle %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_timeout_fail();
        int n;
        push_seg(0, 4, 0); push_seg(1, 20, 0); push_seg(0, 4, 0); push_seg(1, 20, 0);
        push_seg(4, 10, 0); push_seg(0, 2, 0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            rst    = (i == 0 || i == 58);
            locked = 1'b0;
            tick();
            obs   = {loss_count, state, pll_rst, sys_rst, ready, fail};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL timeout_fail cycle %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_run_loss();
        int n;
        push_seg(0, 4, 0); push_seg(1, 1, 0); push_seg(2, 8, 0); push_seg(3, 7, 0);
        push_seg(0, 4, 1); push_seg(1, 1, 1); push_seg(2, 8, 1); push_seg(3, 4, 1);
        push_seg(0, 1, 0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            rst    = (i == 0 || i == 37);
            locked = (i != 18);
            tick();
            obs   = {loss_count, state, pll_rst, sys_rst, ready, fail};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL run_loss cycle %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_stable_drop();
        int n;
        push_seg(0, 4, 0); push_seg(1, 1, 0); push_seg(2, 7, 0); push_seg(1, 1, 0);
        push_seg(2, 8, 0); push_seg(3, 3, 0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            rst    = (i == 0);
            locked = (i != 10);
            tick();
            obs   = {loss_count, state, pll_rst, sys_rst, ready, fail};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL stable_drop cycle %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_lock_priority();
        int n;
        push_seg(0, 4, 0); push_seg(1, 20, 0); push_seg(2, 8, 0); push_seg(3, 4, 0);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            rst    = (i == 0);
            locked = (i >= 22);
            tick();
            obs   = {loss_count, state, pll_rst, sys_rst, ready, fail};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL lock_priority cycle %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_retry_clear();
        int n;
        push_seg(0, 4, 0); push_seg(1, 20, 0); push_seg(0, 4, 0); push_seg(1, 1, 0);
        push_seg(2, 8, 0); push_seg(3, 5, 0);
        push_seg(0, 4, 1); push_seg(1, 20, 1); push_seg(0, 4, 1); push_seg(1, 20, 1);
        push_seg(4, 5, 1);
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            rst    = (i == 0);
            locked = (i >= 25 && i < 40);
            tick();
            obs   = {loss_count, state, pll_rst, sys_rst, ready, fail};
            exp_v = exp_q.pop_front();
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL retry_clear cycle %0d: got %h expected %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_loss_saturate();
        int k;
        rst    = 1'b1;
        locked = 1'b1;
        tick();
        rst = 1'b0;
        k = 0;
        while (state !== 3'd3 && k < 40) begin tick(); k++; end
        n_checks++;
        if (state !== 3'd3) begin
            n_fail++;
            $display("FAIL loss_saturate initial_run: got state %0d expected 3", state);
            return;
        end
        for (int n = 1; n <= 260; n++) begin
            locked = 1'b0;
            tick();
            locked = 1'b1;
            exp_q.push_back(15'((n > 255) ? 255 : n));
            k = 0;
            while (state !== 3'd0 && k < 10) begin tick(); k++; end
            exp_v = exp_q.pop_front();
            obs   = 15'(loss_count);
            n_checks++;
            if (state !== 3'd0 || obs !== exp_v) begin
                n_fail++;
                $display("FAIL loss_saturate loss %0d: got state %0d count %0d expected state 0 count %0d",
                         n, state, obs, exp_v);
                return;
            end
            k = 0;
            while (state !== 3'd3 && k < 30) begin tick(); k++; end
            n_checks++;
            if (state !== 3'd3) begin
                n_fail++;
                $display("FAIL loss_saturate relock %0d: got state %0d expected 3", n, state);
                return;
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_up();
        test_timeout_fail();
        test_run_loss();
        test_stable_drop();
        test_lock_priority();
        test_retry_clear();
        test_loss_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16, cycles pll_rst is held per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 10000, cycles allowed for lock after pll_rst release.
REQ-003 SHALL have parameter STABLE_CYCLES, default 256, consecutive locked cycles required before release.
REQ-004 SHALL have parameter MAX_RETRIES, default 3, lock timeouts tolerated before permanent fail.
REQ-005 SHALL have port refclk  input  1  reference clock; sole clock of the block.
REQ-006 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have port locked  input  1  PLL lock indication, asynchronous to refclk.
REQ-008 SHALL have port pll_rst  output  1  reset to PLL, active-high.
REQ-009 SHALL have port sys_rst  output  1  reset for logic clocked by the PLL output, active-high.
REQ-010 SHALL have port ready  output  1  high only while the clock is qualified (RUN).
REQ-011 SHALL have port fail  output  1  retries exhausted; sticky until rst.
REQ-012 SHALL have port loss_count  output  8  count of lock losses seen in RUN.
REQ-013 SHALL have port state  output  3  current FSM state: 0 PLLRST, 1 WAIT, 2 STABLE, 3 RUN, 4 FAIL.

Function
REQ-014 SHALL synchronize locked through two refclk flops (locked_s); all decisions use locked_s only (2-cycle input latency).
REQ-015 SHALL register all outputs; outputs SHALL reflect the state held in the same cycle, with no combinational input-to-output path.
REQ-016 PLLRST: pll_rst=1, sys_rst=1, ready=0; after exactly PLL_RST_CYCLES cycles in PLLRST, SHALL go to WAIT with counter cleared.
REQ-017 WAIT: pll_rst=0, sys_rst=1; locked_s=1 SHALL go to STABLE with counter cleared.
REQ-018 WAIT: after LOCK_TIMEOUT cycles with locked_s=0, SHALL increment retries; if retries then equals MAX_RETRIES go to FAIL, else go to PLLRST.
REQ-019 STABLE: locked_s=0 on any cycle SHALL return to WAIT with counter cleared; retries unchanged.
REQ-020 STABLE: after STABLE_CYCLES consecutive cycles with locked_s=1, SHALL go to RUN and clear retries.
REQ-021 RUN: sys_rst=0, ready=1, pll_rst=0; locked_s=0 SHALL go to PLLRST and increment loss_count.
REQ-022 loss_count SHALL saturate at 255 (no wrap).
REQ-023 FAIL: pll_rst=1, sys_rst=1, ready=0, fail=1; no exit except rst.
REQ-024 Cycle counter SHALL be sized for max(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES) and cleared on every state change.
REQ-025 If locked_s rises on the same cycle a WAIT timeout expires, lock SHALL take priority (go to STABLE, no retry increment).
REQ-026 sys_rst SHALL deassert only on entry to RUN and SHALL reassert on the first cycle after leaving RUN.

Reset
REQ-027 rst=1 SHALL set state=PLLRST, counter=0, retries=0, loss_count=0, sync flops=0, pll_rst=1, sys_rst=1, ready=0, fail=0.
REQ-028 rst asserted in any state, including FAIL or RUN, SHALL take effect on the next refclk edge.
REQ-029 rst SHALL NOT be used asynchronously; no logic SHALL be sensitive to rst outside the refclk edge.

Verification (bench params: PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
REQ-030 Release rst, locked=1 from start -> pll_rst high 4 cycles; after lock sync and 8 stable cycles, ready=1, sys_rst=0, state=3.
REQ-031 locked held 0 -> two 20-cycle timeouts, each preceded by a 4-cycle pll_rst pulse; then fail=1, state=4, pll_rst=1 until rst.
REQ-032 In RUN, drop locked for 1 cycle -> 2 cycles later state=0, sys_rst=1, ready=0, loss_count=1; relock -> RUN again.
REQ-033 In STABLE, drop locked at stable cycle 5 -> state=1, retries unchanged; full 8-cycle stable window is required again.
REQ-034 Force 260 RUN lock losses -> loss_count=255, not wrapped.
REQ-035 Assert rst for 1 cycle while in FAIL and while in RUN -> all outputs return to REQ-027 values on the next edge.
